escape_seq_parser: RTL and testbench

ESCAPE_SEQ_PARSER -- requirements
Module: escape_seq_parser

---
 rtl/escape_seq_parser.sv | 247 ++++++++++++++++++++++++
 tb/tb_escape_seq_parser.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/escape_seq_parser.sv
// VT-style escape sequence parser: bytes in, one registered command out.
// Ports: clk, rst (async active-low), in_* byte stream, cmd_* command stream.
module escape_seq_parser #(
  parameter int NUM_PARAMS = 16,
  parameter int PARAM_W    = 16,
  localparam int NW = $clog2(NUM_PARAMS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [2:0]                    cmd_kind,
  output logic [7:0]                    cmd_char,
  output logic                          cmd_private,
  output logic [NW-1:0]                 cmd_nparams,
  output logic [NUM_PARAMS*PARAM_W-1:0] cmd_params,
  output logic                          cmd_overflow
);

  localparam int IW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam int PV = NUM_PARAMS * PARAM_W;

  localparam logic [2:0] K_PRINT = 3'd0;
  localparam logic [2:0] K_CTRL  = 3'd1;
  localparam logic [2:0] K_ESC   = 3'd2;
  localparam logic [2:0] K_CSI   = 3'd3;
  localparam logic [2:0] K_INV   = 3'd4;

  typedef enum logic [1:0] {
    GROUND,
    ESCAPE,
    CSI_PARAM,
    CSI_IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic [PV-1:0]   params_q, params_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            priv_q, priv_d;
  logic            ovf_q, ovf_d;
  logic            seen_q, seen_d;

  logic            valid_q, valid_d;
  logic [2:0]      kind_q, kind_d;
  logic [7:0]      char_q, char_d;
  logic            cpriv_q, cpriv_d;
  logic [NW-1:0]   np_q, np_d;
  logic [PV-1:0]   cparams_q, cparams_d;
  logic            covf_q, covf_d;

  logic            fire;
  logic            emit;
  logic            e_csi;
  logic [2:0]      e_kind;
  logic            is_c0;
  logic            is_can;
  logic            is_esc;
  logic            is_dig;
  logic            is_fin;
  logic [PARAM_W-1:0] cur_p;
  logic [PARAM_W-1:0] new_p;
  logic [PARAM_W+3:0] prod;

  assign in_ready = !valid_q || cmd_ready;
  assign fire     = in_valid && in_ready;

  assign is_c0  = (in_data < 8'h20);
  assign is_can = (in_data == 8'h18) || (in_data == 8'h1A);
  assign is_esc = (in_data == 8'h1B);
  assign is_dig = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_fin = (in_data >= 8'h40) && (in_data <= 8'h7E);

  // p*10 + d in a 4-bit-wider accumulator; any carry out means saturate
  assign cur_p = params_q[idx_q*PARAM_W +: PARAM_W];
  assign prod  = ({4'b0, cur_p} << 3) + ({4'b0, cur_p} << 1)
               + (PARAM_W+4)'(in_data[3:0]);
  assign new_p = (|prod[PARAM_W+3:PARAM_W]) ? '1 : prod[PARAM_W-1:0];

  always_comb begin
    state_d  = state_q;
    params_d = params_q;
    idx_d    = idx_q;
    priv_d   = priv_q;
    ovf_d    = ovf_q;
    seen_d   = seen_q;
    emit     = 1'b0;
    e_csi    = 1'b0;
    e_kind   = K_PRINT;
    if (fire) begin
      if (is_c0 && state_q != GROUND && !is_can && !is_esc) begin
        emit   = 1'b1;
        e_kind = K_CTRL;
      end else begin
        unique case (state_q)
          GROUND: begin
            if (is_esc) begin
              state_d = ESCAPE;
            end else if (is_c0) begin
              emit   = 1'b1;
              e_kind = K_CTRL;
            end else if (in_data < 8'h7F) begin
              emit   = 1'b1;
              e_kind = K_PRINT;
            end else if (in_data[7]) begin
              emit   = 1'b1;
              e_kind = K_INV;
            end
          end
          ESCAPE: begin
            if (in_data == 8'h5B) begin
              state_d  = CSI_PARAM;
              params_d = '0;
              idx_d    = '0;
              priv_d   = 1'b0;
              ovf_d    = 1'b0;
              seen_d   = 1'b0;
            end else if (is_can) begin
              state_d = GROUND;
            end else if (in_data >= 8'h30 && in_data <= 8'h7E) begin
              emit    = 1'b1;
              e_kind  = K_ESC;
              state_d = GROUND;
            end else if (in_data[7]) begin
              emit    = 1'b1;
              e_kind  = K_INV;
              state_d = GROUND;
            end
          end
          CSI_PARAM: begin
            if (is_esc) begin
              state_d = ESCAPE;
            end else if (is_can) begin
              state_d = GROUND;
            end else if (is_dig) begin
              seen_d = 1'b1;
              if (!ovf_q) begin
                params_d[idx_q*PARAM_W +: PARAM_W] = new_p;
              end
            end else if (in_data == 8'h3B) begin
              seen_d = 1'b1;
              if (idx_q == IW'(NUM_PARAMS - 1)) begin
                ovf_d = 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else if (in_data == 8'h3F) begin
              if (!seen_q && !priv_q) begin
                priv_d = 1'b1;
              end else begin
                state_d = CSI_IGNORE;
              end
            end else if (is_fin) begin
              emit    = 1'b1;
              e_csi   = 1'b1;
              e_kind  = K_CSI;
              state_d = GROUND;
            end else if (in_data != 8'h7F) begin
              state_d = CSI_IGNORE;
            end
          end
          CSI_IGNORE: begin
            if (is_esc) begin
              state_d = ESCAPE;
            end else if (is_can) begin
              state_d = GROUND;
            end else if (is_fin) begin
              emit    = 1'b1;
              e_kind  = K_INV;
              state_d = GROUND;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    kind_d    = kind_q;
    char_d    = char_q;
    cpriv_d   = cpriv_q;
    np_d      = np_q;
    cparams_d = cparams_q;
    covf_d    = covf_q;
    if (fire && emit) begin
      valid_d   = 1'b1;
      kind_d    = e_kind;
      char_d    = in_data;
      cpriv_d   = e_csi && priv_q;
      np_d      = '0;
      cparams_d = '0;
      covf_d    = e_csi && ovf_q;
      if (e_csi) begin
        cparams_d = params_q;
        if (seen_q) begin
          np_d = NW'(idx_q) + NW'(1);
        end
      end
    end else if (cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= GROUND;
      params_q  <= '0;
      idx_q     <= '0;
      priv_q    <= 1'b0;
      ovf_q     <= 1'b0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
      kind_q    <= '0;
      char_q    <= '0;
      cpriv_q   <= 1'b0;
      np_q      <= '0;
      cparams_q <= '0;
      covf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      params_q  <= params_d;
      idx_q     <= idx_d;
      priv_q    <= priv_d;
      ovf_q     <= ovf_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
      kind_q    <= kind_d;
      char_q    <= char_d;
      cpriv_q   <= cpriv_d;
      np_q      <= np_d;
      cparams_q <= cparams_d;
      covf_q    <= covf_d;
    end
  end

  assign cmd_valid    = valid_q;
  assign cmd_kind     = kind_q;
  assign cmd_char     = char_q;
  assign cmd_private  = cpriv_q;
  assign cmd_nparams  = np_q;
  assign cmd_params   = cparams_q;
  assign cmd_overflow = covf_q;

endmodule

// File: tb/tb_escape_seq_parser.sv
// Scoreboard bench for escape_seq_parser (NUM_PARAMS=4, PARAM_W=16).
// Expected commands are queued as bytes are sent and popped on handshake.
module tb_escape_seq_parser;

  localparam int NP = 4;
  localparam int PW = 16;
  localparam int NW = $clog2(NP + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_ready;
  logic            cmd_valid;
  logic            cmd_ready = 1'b1;
  logic [2:0]      cmd_kind;
  logic [7:0]      cmd_char;
  logic            cmd_private;
  logic [NW-1:0]   cmd_nparams;
  logic [NP*PW-1:0] cmd_params;
  logic            cmd_overflow;

  escape_seq_parser #(
    .NUM_PARAMS(NP),
    .PARAM_W   (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_kind    (cmd_kind),
    .cmd_char    (cmd_char),
    .cmd_private (cmd_private),
    .cmd_nparams (cmd_nparams),
    .cmd_params  (cmd_params),
    .cmd_overflow(cmd_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       kind;
    logic [7:0]       ch;
    logic             priv;
    logic [NW-1:0]    np;
    logic [NP*PW-1:0] p;
    logic             ovf;
  } cmd_t;

  cmd_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   stall_en = 1'b0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic cmd_t cur();
    return {cmd_kind, cmd_char, cmd_private,
            cmd_nparams, cmd_params, cmd_overflow};
  endfunction

  task automatic exp_cmd(logic [2:0] k, logic [7:0] c,
                         logic pv = 1'b0, int n = 0,
                         logic [NP*PW-1:0] p = '0,
                         logic ov = 1'b0);
    cmd_t e;
    e.kind = k;
    e.ch   = c;
    e.priv = pv;
    e.np   = NW'(n);
    e.p    = p;
    e.ovf  = ov;
    sb.push_back(e);
  endtask

  task automatic send(logic [7:0] b);
    int g;
    @(negedge clk);
    #2;
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      #2;
      g++;
    end
    if (g >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(8'(s[i]));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: drives cmd_ready (optional 3-cycle stall per command),
  // checks stall behaviour, and pops the scoreboard on each handshake.
  initial begin
    cmd_t e;
    cmd_t snap;
    int   wcnt;
    wcnt = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wcnt = 0;
        cmd_ready = 1'b1;
        continue;
      end
      cmd_ready = !(stall_en && cmd_valid && wcnt < 3);
      #1;
      if (cmd_valid && !cmd_ready) begin
        chk("in_ready_stall", in_ready, 0);
        if (wcnt == 0) snap = cur();
        else chk("stable", cur() == snap, 1);
        wcnt++;
      end else if (cmd_valid) begin
        wcnt = 0;
        if (sb.size() == 0) begin
          chk("unexpected_cmd", {cmd_kind, cmd_char}, 0);
        end else begin
          e = sb.pop_front();
          chk("kind", cmd_kind, e.kind);
          chk("char", cmd_char, e.ch);
          chk("private", cmd_private, e.priv);
          chk("nparams", cmd_nparams, e.np);
          chk("params", cmd_params, e.p);
          chk("overflow", cmd_overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_kind", cmd_kind, 0);
    chk("rst_params", cmd_params, 0);
    @(negedge clk);
    rst = 1'b1;

    exp_cmd(3'd0, 8'h41);
    send(8'h41);
    exp_cmd(3'd1, 8'h0A);
    send(8'h0A);
    send(8'h7F);
    exp_cmd(3'd4, 8'h80);
    send(8'h80);

    exp_cmd(3'd3, 8'h48, 0, 2, {16'd0, 16'd0, 16'd34, 16'd12});
    send(8'h1B); send_str("[12;34H");
    exp_cmd(3'd3, 8'h6C, 1, 1, 64'd25);
    send(8'h1B); send_str("[?25l");
    exp_cmd(3'd3, 8'h6D, 0, 1, 64'd65535);
    send(8'h1B); send_str("[70000m");
    exp_cmd(3'd3, 8'h6D, 0, 4,
            {16'd4, 16'd3, 16'd2, 16'd1}, 1);
    send(8'h1B); send_str("[1;2;3;4;5;6m");
    exp_cmd(3'd3, 8'h6D, 0, 0, 64'd0);
    send(8'h1B); send_str("[m");
    exp_cmd(3'd3, 8'h6D, 0, 2, {16'd0, 16'd0, 16'd5, 16'd0});
    send(8'h1B); send_str("[;5m");
    exp_cmd(3'd2, 8'h63);
    send(8'h1B); send_str("c");
    exp_cmd(3'd3, 8'h41, 0, 1, 64'd4);
    send(8'h1B); send_str("[3");
    send(8'h1B); send_str("[4A");
    exp_cmd(3'd4, 8'h6D);
    send(8'h1B); send_str("[1:2m");
    exp_cmd(3'd0, 8'h42);
    send(8'h1B); send_str("[5");
    send(8'h18); send_str("B");
    drain();

    stall_en = 1'b1;
    exp_cmd(3'd1, 8'h0A);
    exp_cmd(3'd3, 8'h6D, 0, 1, 64'd5);
    send(8'h1B); send_str("[5");
    send(8'h0A); send_str("m");
    drain();
    stall_en = 1'b0;

    send(8'h1B); send_str("[9");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", cmd_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_cmd(3'd0, 8'h41);
    send(8'h41);
    drain();

    repeat (10) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
